// File: rtl/avalon_mm_mem_responder_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avalon_mm_mem_responder_pkg;

  // Bus widths shared with the SDRAM controller's DDR3-side master port
  localparam int DFLT_ADDR_WID = 27;
  localparam int DFLT_DATA_WID = 32;
  localparam int BC_WID        = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } state_e;

  // A zero burstcount is serviced as a single beat
  function automatic logic [BC_WID-1:0] eff_beats(input logic [BC_WID-1:0] bc);
    return (bc == '0) ? BC_WID'(1) : bc;
  endfunction

endpackage

// File: rtl/avalon_mm_mem_responder_if.sv
// Avalon-MM slave bus bundle (command, write data, read return).
interface avalon_mm_mem_responder_if
  import avalon_mm_mem_responder_pkg::*;
#(
  parameter int ADDR_WID = DFLT_ADDR_WID,
  parameter int DATA_WID = DFLT_DATA_WID
);
  logic                AVS_S0_READ;
  logic                AVS_S0_WRITE;
  logic [ADDR_WID-1:0] AVS_S0_ADDRESS;
  logic [DATA_WID-1:0] AVS_S0_WRITEDATA;
  logic [BC_WID-1:0]   AVS_S0_BURSTCOUNT;
  logic                AVS_S0_WAITREQUEST;
  logic [DATA_WID-1:0] AVS_S0_READDATA;
  logic                AVS_S0_READDATAVALID;

  modport slave (
    input  AVS_S0_READ, AVS_S0_WRITE, AVS_S0_ADDRESS, AVS_S0_WRITEDATA, AVS_S0_BURSTCOUNT,
    output AVS_S0_WAITREQUEST, AVS_S0_READDATA, AVS_S0_READDATAVALID
  );

  modport master (
    output AVS_S0_READ, AVS_S0_WRITE, AVS_S0_ADDRESS, AVS_S0_WRITEDATA, AVS_S0_BURSTCOUNT,
    input  AVS_S0_WAITREQUEST, AVS_S0_READDATA, AVS_S0_READDATAVALID
  );
endinterface

// File: rtl/avalon_mm_mem_responder_rd_delay.sv
// Valid+data shift pipeline that pads the RAM read to the configured latency.
// Data stages only load on a valid beat, so the output holds the last beat.
module avalon_rd_delay_line #(
  parameter int DATA_WID = 32,
  parameter int DEPTH    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                vld_i,
  input  logic [DATA_WID-1:0] data_i,
  output logic                vld_o,
  output logic [DATA_WID-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    assign vld_o  = vld_i;
    assign data_o = data_i;
  end else begin : g_pipe
    logic [DEPTH-1:0]    vld_q;
    logic [DATA_WID-1:0] data_q [DEPTH];

    // Shift beats down the pipe; flush discards anything in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        if (vld_i) data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];
  end

endmodule

// File: rtl/avalon_mm_mem_responder.sv
// Avalon-MM slave backed by an internal RAM: DDR3 stand-in with forced
// stalls, burst read/write and fixed read latency.
module avalon_mm_mem_responder
  import avalon_mm_mem_responder_pkg::*;
#(
  parameter int ADDR_WID     = DFLT_ADDR_WID,
  parameter int DATA_WID     = DFLT_DATA_WID,
  parameter int MEM_AWID     = 10,
  parameter int RD_LATENCY   = 3,
  parameter int STALL_PERIOD = 0
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  avalon_mm_mem_responder_if.slave  avs,
  output logic                      ERR_FLAG
);

  localparam int CNT_W = 8;

  state_e              state_q, state_d;
  logic [MEM_AWID-1:0] addr_q, addr_d;
  logic [BC_WID-1:0]   left_q, left_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q, err_set;
  logic                stall, waitreq;

  logic                ram_we;
  logic [MEM_AWID-1:0] ram_waddr;
  logic                rd_issue;
  logic [MEM_AWID-1:0] rd_addr;
  logic                rd_vld_q;
  logic [DATA_WID-1:0] rd_data_q;
  logic [DATA_WID-1:0] mem [1 << MEM_AWID];

  logic [MEM_AWID-1:0] addr_lo;
  logic                addr_hi_err;
  logic [BC_WID-1:0]   beats;

  assign addr_lo     = avs.AVS_S0_ADDRESS[MEM_AWID-1:0];
  assign addr_hi_err = |avs.AVS_S0_ADDRESS[ADDR_WID-1:MEM_AWID];
  assign beats       = eff_beats(avs.AVS_S0_BURSTCOUNT);
  assign stall       = (STALL_PERIOD != 0) && (cnt_q == CNT_W'(STALL_PERIOD - 1));

  // Waitrequest: held during reset and for the whole read burst, else forced stall
  always_comb begin
    waitreq = stall;
    if (!RESET_N || state_q == ST_RD_BURST) waitreq = 1'b1;
  end

  // Command acceptance, burst sequencing and RAM port control
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    rd_issue  = 1'b0;
    rd_addr   = addr_q;
    err_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((avs.AVS_S0_READ || avs.AVS_S0_WRITE) && !waitreq) begin
          err_set = (avs.AVS_S0_BURSTCOUNT == '0) || addr_hi_err ||
                    (avs.AVS_S0_READ && avs.AVS_S0_WRITE);
          addr_d  = addr_lo + MEM_AWID'(1);
          left_d  = beats - BC_WID'(1);
          if (avs.AVS_S0_WRITE) begin
            ram_we    = 1'b1;
            ram_waddr = addr_lo;
            if (beats > BC_WID'(1)) state_d = ST_WR_BURST;
          end else begin
            rd_issue = 1'b1;
            rd_addr  = addr_lo;
            if (beats > BC_WID'(1)) state_d = ST_RD_BURST;
          end
        end
      end
      ST_WR_BURST: begin
        if (avs.AVS_S0_READ) err_set = 1'b1;
        if (avs.AVS_S0_WRITE && !waitreq) begin
          ram_we = 1'b1;
          addr_d = addr_q + MEM_AWID'(1);
          left_d = left_q - BC_WID'(1);
          if (left_q == BC_WID'(1)) state_d = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + MEM_AWID'(1);
        left_d   = left_q - BC_WID'(1);
        if (left_q == BC_WID'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, stall counter and sticky error
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      if (STALL_PERIOD == 0 || cnt_q == CNT_W'(STALL_PERIOD - 1)) cnt_q <= '0;
      else                                                        cnt_q <= cnt_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  // RAM write port (contents survive reset)
  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_waddr] <= avs.AVS_S0_WRITEDATA;
  end

  // Registered RAM read: first cycle of the read latency
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) rd_data_q <= mem[rd_addr];
    end
  end

  avalon_rd_delay_line #(
    .DATA_WID (DATA_WID),
    .DEPTH    (RD_LATENCY - 1)
  ) u_rd_delay (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .vld_i  (rd_vld_q),
    .data_i (rd_data_q),
    .vld_o  (avs.AVS_S0_READDATAVALID),
    .data_o (avs.AVS_S0_READDATA)
  );

  assign avs.AVS_S0_WAITREQUEST = waitreq;
  assign ERR_FLAG               = err_q;

endmodule

// File: tb/tb_avalon_mm_mem_responder.sv
// Directed bench: dut0 without stalls (latency 3), dut1 with a 4-cycle stall period.
module tb_avalon_mm_mem_responder;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  avalon_mm_mem_responder_if m0 ();
  avalon_mm_mem_responder_if m1 ();
  logic err0, err1;

  avalon_mm_mem_responder #(.ADDR_WID(27), .DATA_WID(32), .MEM_AWID(10),
                            .RD_LATENCY(3), .STALL_PERIOD(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .avs(m0), .ERR_FLAG(err0));

  avalon_mm_mem_responder #(.ADDR_WID(27), .DATA_WID(32), .MEM_AWID(10),
                            .RD_LATENCY(3), .STALL_PERIOD(4)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .avs(m1), .ERR_FLAG(err1));

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int mcnt = 0;
  int wr0_hi = 0;
  int q0t[$];
  logic [31:0] q0d[$];
  int q1t[$];
  logic [31:0] q1d[$];

  always @(posedge CLK) begin
    cyc = cyc + 1;
    mcnt = (!RESET_N) ? 0 : (mcnt + 1) % 4;
  end

  always @(negedge CLK) begin
    if (m0.AVS_S0_READDATAVALID === 1'b1) begin
      q0t.push_back(cyc);
      q0d.push_back(m0.AVS_S0_READDATA);
    end
    if (m1.AVS_S0_READDATAVALID === 1'b1) begin
      q1t.push_back(cyc);
      q1d.push_back(m1.AVS_S0_READDATA);
    end
    if (RESET_N && m0.AVS_S0_WAITREQUEST === 1'b1) wr0_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clrq0();
    q0t.delete();
    q0d.delete();
  endtask

  // Write burst on dut0; data for beat k is d0 + k*step
  task automatic wburst0(input logic [26:0] a, input logic [10:0] bc,
                         input logic [31:0] d0, input logic [31:0] step);
    int k = 0;
    int guard = 0;
    int n = (bc == 0) ? 1 : int'(bc);
    logic acc;
    m0.AVS_S0_WRITE = 1'b1;
    m0.AVS_S0_ADDRESS = a;
    m0.AVS_S0_BURSTCOUNT = bc;
    while (k < n && guard < 200) begin
      m0.AVS_S0_WRITEDATA = d0 + k * step;
      acc = !m0.AVS_S0_WAITREQUEST;
      @(posedge CLK);
      @(negedge CLK);
      if (acc) k++;
      guard++;
    end
    m0.AVS_S0_WRITE = 1'b0;
    chk("wr_beats_done", k, n);
  endtask

  // Issue a read on dut0; t = cycle of acceptance, w = cycles spent waiting
  task automatic rd0(input logic [26:0] a, input logic [10:0] bc, output int t, output int w);
    int guard = 0;
    w = 0;
    m0.AVS_S0_READ = 1'b1;
    m0.AVS_S0_ADDRESS = a;
    m0.AVS_S0_BURSTCOUNT = bc;
    while (m0.AVS_S0_WAITREQUEST && guard < 100) begin
      w++;
      @(negedge CLK);
      guard++;
    end
    chk("rd_accept_in_time", (guard < 100), 1);
    t = cyc;
    @(posedge CLK);
    @(negedge CLK);
    m0.AVS_S0_READ = 1'b0;
  endtask

  task automatic wait_beats0(input string tag, input int n);
    int guard = 0;
    while (q0t.size() < n && guard < 60) begin
      @(negedge CLK);
      guard++;
    end
    chk(tag, q0t.size(), n);
  endtask

  task automatic beat0(input string tag, input int k, input int et, input logic [31:0] ed);
    if (k < q0t.size()) begin
      chk({tag, "_time"}, q0t[k], et);
      chk({tag, "_data"}, q0d[k], ed);
    end else begin
      chk({tag, "_missing"}, 0, 1);
    end
  endtask

  task automatic rd_single0(input string tag, input logic [26:0] a, input logic [31:0] ed);
    int t, w;
    clrq0();
    rd0(a, 11'd1, t, w);
    wait_beats0({tag, "_cnt"}, 1);
    beat0(tag, 0, t + 3, ed);
    clrq0();
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int t, t2, w, w2, k, guard;
  logic acc;

  initial begin
    m0.AVS_S0_READ = 0; m0.AVS_S0_WRITE = 0; m0.AVS_S0_ADDRESS = '0;
    m0.AVS_S0_WRITEDATA = '0; m0.AVS_S0_BURSTCOUNT = 11'd1;
    m1.AVS_S0_READ = 0; m1.AVS_S0_WRITE = 0; m1.AVS_S0_ADDRESS = '0;
    m1.AVS_S0_WRITEDATA = '0; m1.AVS_S0_BURSTCOUNT = 11'd1;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_waitreq", m0.AVS_S0_WAITREQUEST, 1);
    chk("rst_rdv", m0.AVS_S0_READDATAVALID, 0);
    chk("rst_rdata", m0.AVS_S0_READDATA, 0);
    chk("rst_err", err0, 0);
    chk("rst_waitreq1", m1.AVS_S0_WAITREQUEST, 1);
    #2 RESET_N = 1'b1;
    @(negedge CLK);

    // dut1: 8-beat write with periodic stalls; stall cycles carry junk data
    m1.AVS_S0_WRITE = 1'b1;
    m1.AVS_S0_ADDRESS = 27'h100;
    m1.AVS_S0_BURSTCOUNT = 11'd8;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 40) begin
      chk("stall_waitreq", m1.AVS_S0_WAITREQUEST, (mcnt == 3));
      m1.AVS_S0_WRITEDATA = m1.AVS_S0_WAITREQUEST ? (32'hBAD0_0000 + guard) : (32'hA0 + k);
      acc = !m1.AVS_S0_WAITREQUEST;
      @(posedge CLK);
      @(negedge CLK);
      if (acc) k++;
      guard++;
    end
    m1.AVS_S0_WRITE = 1'b0;
    chk("stall_beats_written", k, 8);
    chk("stall_cycles_taken", guard, 10);
    m1.AVS_S0_READ = 1'b1;
    guard = 0;
    while (m1.AVS_S0_WAITREQUEST && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    t = cyc;
    @(posedge CLK);
    @(negedge CLK);
    m1.AVS_S0_READ = 1'b0;
    guard = 0;
    while (q1t.size() < 8 && guard < 60) begin
      @(negedge CLK);
      guard++;
    end
    chk("stall_rd_cnt", q1t.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q1t.size()) begin
        chk("stall_rd_time", q1t[i], t + 3 + i);
        chk("stall_rd_data", q1d[i], 32'hA0 + i);
      end
    end
    chk("stall_err", err1, 0);

    // Single write then read at 0x005
    wr0_hi = 0;
    wburst0(27'h005, 11'd1, 32'hDEADBEEF, 32'h0);
    clrq0();
    rd0(27'h005, 11'd1, t, w);
    wait_beats0("single_cnt", 1);
    beat0("single", 0, t + 3, 32'hDEADBEEF);
    chk("single_no_waitreq", wr0_hi, 0);
    clrq0();

    // Wrapping 4-beat burst at 0x3FE
    wburst0(27'h3FE, 11'd4, 32'h11, 32'h11);
    rd0(27'h3FE, 11'd4, t, w);
    wait_beats0("wrap_cnt", 4);
    for (int i = 0; i < 4; i++) beat0("wrap", i, t + 3 + i, 32'h11 * (i + 1));
    clrq0();
    rd_single0("wrap_3ff", 27'h3FF, 32'h22);
    rd_single0("wrap_000", 27'h000, 32'h33);

    // 16-beat read immediately followed by a single read
    wburst0(27'h020, 11'd16, 32'h1000, 32'h1);
    clrq0();
    rd0(27'h020, 11'd16, t, w);
    rd0(27'h005, 11'd1, t2, w2);
    chk("b16_waitreq_cycles", w2, 15);
    chk("b16_second_accept", t2, t + 16);
    wait_beats0("b16_cnt", 17);
    for (int i = 0; i < 17; i++)
      beat0("b16", i, t + 3 + i, (i < 16) ? (32'h1000 + i) : 32'hDEADBEEF);
    chk("b16_err", err0, 0);
    clrq0();

    // Error cases: zero burstcount, out-of-range address, read+write together
    rd0(27'h000, 11'd0, t, w);
    wait_beats0("bc0_cnt", 1);
    repeat (6) @(negedge CLK);
    chk("bc0_one_beat", q0t.size(), 1);
    beat0("bc0", 0, t + 3, 32'h33);
    chk("bc0_err", err0, 1);
    clrq0();
    pulse_reset();
    chk("err_cleared", err0, 0);
    rd_single0("hiaddr", 27'h400, 32'h33);
    chk("hiaddr_err", err0, 1);
    pulse_reset();
    m0.AVS_S0_READ = 1'b1;
    m0.AVS_S0_WRITE = 1'b1;
    m0.AVS_S0_ADDRESS = 27'h010;
    m0.AVS_S0_BURSTCOUNT = 11'd1;
    m0.AVS_S0_WRITEDATA = 32'h5A5A5A5A;
    @(posedge CLK);
    @(negedge CLK);
    m0.AVS_S0_READ = 1'b0;
    m0.AVS_S0_WRITE = 1'b0;
    repeat (6) @(negedge CLK);
    chk("rw_no_read_beat", q0t.size(), 0);
    chk("rw_err", err0, 1);
    rd_single0("rw_write_won", 27'h010, 32'h5A5A5A5A);
    chk("rw_err_sticky", err0, 1);

    // Reset during an 8-beat read burst
    clrq0();
    rd0(27'h020, 11'd8, t, w);
    guard = 0;
    while (cyc < t + 6 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_beats_before", q0t.size(), 4);
    chk("midrst_waitreq", m0.AVS_S0_WAITREQUEST, 1);
    chk("midrst_rdv", m0.AVS_S0_READDATAVALID, 0);
    chk("midrst_rdata", m0.AVS_S0_READDATA, 0);
    chk("midrst_err", err0, 0);
    clrq0();
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("midrst_no_beats", q0t.size(), 0);
    rd_single0("after_rst", 27'h3FE, 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
